// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU datapath blocks that touch the register file.
//   REG_ZERO    : architectural address of the hardwired-zero register
//   dbg_state_t : state encoding of the register-file debug read handshake
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_ZERO = 0;

    typedef enum logic [0:0] {
        DBG_IDLE = 1'b0,
        DBG_RESP = 1'b1
    } dbg_state_t;

endpackage

// File: rtl/regfile_byte_merge.sv
// ---------------------------------------------------------------------------
// regfile_byte_merge
// Combinational byte-lane merge of a partial register write.
// Enabled lanes take the new data. Disabled lanes keep the old word, or read
// as zero when the old entry has never been written since reset.
// Ports:
//   old_i    : current stored word of the target entry
//   valid_i  : target entry has been written since reset
//   wd_i     : incoming write data
//   wbe_i    : byte enables, bit b covers wd_i[8b+7:8b]
//   merged_o : word the entry holds after the write
// ---------------------------------------------------------------------------
module regfile_byte_merge
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic                valid_i,
    input  logic [DATA_W-1:0]   wd_i,
    input  logic [DATA_W/8-1:0] wbe_i,
    output logic [DATA_W-1:0]   merged_o
);

    localparam int NB = DATA_W / 8;

    // Lanes default to zero so an invalid entry never leaks stale storage.
    always_comb begin
        merged_o = '0;
        for (int b = 0; b < NB; b++) begin
            if (wbe_i[b]) begin
                merged_o[8*b +: 8] = wd_i[8*b +: 8];
            end else if (valid_i) begin
                merged_o[8*b +: 8] = old_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
// CPU register file between decode (read addresses) and writeback (write
// port). NUM_RD registered read ports, one byte-enabled write port, optional
// write-to-read bypass, optional hardwired-zero register 0, and a debug read
// port with a req/ack handshake for test/monitor logic.
// Storage carries no reset so it can map onto RAM; the cleared state after
// reset is held in a per-entry valid bitmap instead.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   we/wa/wd   : write enable, address, data
//   wbe        : write byte enables, bit i covers wd[8i+7:8i]
//   ra         : packed read addresses, port i = ra[i*AW +: AW]
//   rd         : packed registered read data, port i = rd[i*DATA_W +: DATA_W]
//   dbg_req    : debug read request
//   dbg_addr   : debug read address
//   dbg_ack    : one-cycle pulse, dbg_data is valid
//   dbg_data   : debug read data, held until the next ack
// ---------------------------------------------------------------------------
module regfile_multiport
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [AW-1:0]            wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic [NUM_RD*AW-1:0]     ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     dbg_req,
    input  logic [AW-1:0]            dbg_addr,
    output logic                     dbg_ack,
    output logic [DATA_W-1:0]        dbg_data
);

    // Addresses are AW bits wide; when DEPTH is not a power of two some
    // encodings have no backing entry and must read as zero.
    function automatic logic addrInRange(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic isZeroAddr(input logic [AW-1:0] a);
        return (ZERO_REG != 1'b0) && (a == AW'(REG_ZERO));
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic              wrFire;
    logic [AW-1:0]     waSafe;
    logic [DATA_W-1:0] wrOld;
    logic              wrOldValid;
    logic [DATA_W-1:0] wrMerged;

    // A write only takes effect with at least one byte enabled, a real
    // target entry, and not aimed at the hardwired-zero register.
    always_comb begin
        wrFire     = we && (|wbe) && addrInRange(wa) && !isZeroAddr(wa);
        waSafe     = addrInRange(wa) ? wa : '0;
        wrOld      = mem[waSafe];
        wrOldValid = valid_q[waSafe];
    end

    // One merge serves both the storage update and the bypass path, so a
    // bypassed read always sees exactly the word that lands in storage.
    regfile_byte_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_i    (wrOld),
        .valid_i  (wrOldValid),
        .wd_i     (wd),
        .wbe_i    (wbe),
        .merged_o (wrMerged)
    );

    // Reset-free storage keeps the array RAM-inferable.
    always_ff @(posedge clk) begin
        if (wrFire) begin
            mem[waSafe] <= wrMerged;
        end
    end

    // Valid bitmap is the only reset state of the array contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wrFire) begin
            valid_q[waSafe] <= 1'b1;
        end
    end

    // Each read port resolves its address independently; ports may share an
    // address. With bypass, a same-edge write to the port's address wins.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [AW-1:0]     addrSafe;
        logic [DATA_W-1:0] rdPort_d;
        logic [DATA_W-1:0] rdPort_q;

        assign addr = ra[p*AW +: AW];

        always_comb begin
            addrSafe = addrInRange(addr) ? addr : '0;
            rdPort_d = '0;
            if (addrInRange(addr) && !isZeroAddr(addr)) begin
                if ((BYPASS != 1'b0) && wrFire && (addr == wa)) begin
                    rdPort_d = wrMerged;
                end else if (valid_q[addrSafe]) begin
                    rdPort_d = mem[addrSafe];
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdPort_q <= '0;
            end else begin
                rdPort_q <= rdPort_d;
            end
        end

        assign rd[p*DATA_W +: DATA_W] = rdPort_q;
    end

    logic [AW-1:0]     dbgAddrSafe;
    logic [DATA_W-1:0] dbgPreWrite;

    // The debug port never bypasses: it always observes the pre-write value,
    // even when a write to the same entry lands on the same edge.
    always_comb begin
        dbgAddrSafe = addrInRange(dbg_addr) ? dbg_addr : '0;
        dbgPreWrite = '0;
        if (addrInRange(dbg_addr) && !isZeroAddr(dbg_addr) && valid_q[dbgAddrSafe]) begin
            dbgPreWrite = mem[dbgAddrSafe];
        end
    end

    dbg_state_t        dbgState_q;
    dbg_state_t        dbgState_d;
    logic [DATA_W-1:0] dbgData_q;
    logic [DATA_W-1:0] dbgData_d;

    // Debug handshake state and captured data. Reset drops any pending
    // request so no ack follows a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbgState_q <= DBG_IDLE;
            dbgData_q  <= '0;
        end else begin
            dbgState_q <= dbgState_d;
            dbgData_q  <= dbgData_d;
        end
    end

    // IDLE captures on request; RESP acks for one cycle and ignores dbg_req,
    // so a held request yields one ack every two cycles.
    always_comb begin
        dbgState_d = dbgState_q;
        dbgData_d  = dbgData_q;
        dbg_ack    = 1'b0;
        case (dbgState_q)
            DBG_IDLE: begin
                if (dbg_req) begin
                    dbgData_d  = dbgPreWrite;
                    dbgState_d = DBG_RESP;
                end
            end
            DBG_RESP: begin
                dbg_ack    = 1'b1;
                dbgState_d = DBG_IDLE;
            end
            default: begin
                dbgState_d = DBG_IDLE;
            end
        endcase
    end

    assign dbg_data = dbgData_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport
// Directed bench for regfile_multiport. Two instances share all inputs: dutA
// with write-first bypass, dutB read-first. Expected outputs are queued when
// inputs are driven and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_regfile_multiport;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic [9:0]  ra;
    logic        dbg_req;
    logic [4:0]  dbg_addr;

    logic [63:0] rdA;
    logic [63:0] rdB;
    logic        ackA;
    logic        ackB;
    logic [31:0] dataA;
    logic [31:0] dataB;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];

    regfile_multiport #(
        .DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dutA (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
        .ra(ra), .rd(rdA), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_ack(ackA), .dbg_data(dataA)
    );

    regfile_multiport #(
        .DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dutB (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
        .ra(ra), .rd(rdB), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_ack(ackB), .dbg_data(dataB)
    );

    always #5 clk = ~clk;

    // Output selectors: 0/1 dutA ports, 2/3 dutB ports, 4/5 dutA debug
    // data/ack, 6/7 dutB debug data/ack.
    function automatic logic [31:0] getObs(input int sel);
        case (sel)
            0:       return rdA[31:0];
            1:       return rdA[63:32];
            2:       return rdB[31:0];
            3:       return rdB[63:32];
            4:       return dataA;
            5:       return {31'b0, ackA};
            6:       return dataB;
            7:       return {31'b0, ackB};
            default: return 32'hxxxxxxxx;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expectNext(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.due = cyc + 1;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic weV, input logic [4:0] waV, input logic [31:0] wdV,
                                 input logic [3:0] wbeV, input logic [4:0] ra0V,
                                 input logic [4:0] ra1V, input logic reqV,
                                 input logic [4:0] addrV);
        we       = weV;
        wa       = waV;
        wd       = wdV;
        wbe      = wbeV;
        ra       = {ra1V, ra0V};
        dbg_req  = reqV;
        dbg_addr = addrV;
    endtask

    // Advance one clock, sample 1 ns after the edge, retire due entries.
    task automatic stepCycle();
        exp_t keep[$];
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due <= cyc) begin
                checkOutput(sb[i].tag, getObs(sb[i].sel), sb[i].val);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        #12;
        checkOutput("reset_rdA0", rdA[31:0], 32'h0);
        checkOutput("reset_rdA1", rdA[63:32], 32'h0);
        checkOutput("reset_rdB0", rdB[31:0], 32'h0);
        checkOutput("reset_ackA", {31'b0, ackA}, 32'h0);
        checkOutput("reset_dataA", dataA, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Every address reads zero after reset; debug read of r5 acks once.
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'(a), 5'(31 - a), a == 0, 5'd5);
            expectNext("t1_rdA0", 0, 32'h0);
            expectNext("t1_rdA1", 1, 32'h0);
            expectNext("t1_rdB0", 2, 32'h0);
            if (a == 0) begin
                expectNext("t1_dbg_ack", 5, 32'h1);
                expectNext("t1_dbg_data", 4, 32'h0);
            end
            if (a == 1) begin
                expectNext("t1_dbg_single_ack", 5, 32'h0);
            end
            stepCycle();
        end

        // Full write then partial byte write to r3, with a same-edge debug read.
        applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 5'd3, 5'd0, 1'b0, 5'd0);
        expectNext("t2_full_bypass", 0, 32'hDEADBEEF);
        expectNext("t2_full_readfirst", 2, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 5'd3, 32'h00001200, 4'h2, 5'd3, 5'd3, 1'b1, 5'd3);
        expectNext("t2_part_bypass0", 0, 32'hDEAD12EF);
        expectNext("t2_part_bypass1", 1, 32'hDEAD12EF);
        expectNext("t2_part_readfirst", 2, 32'hDEADBEEF);
        expectNext("t2_dbg_prewrite", 4, 32'hDEADBEEF);
        expectNext("t2_dbg_ack", 5, 32'h1);
        expectNext("t2_dbgB_prewrite", 6, 32'hDEADBEEF);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3, 1'b0, 5'd0);
        expectNext("t2_after_A", 0, 32'hDEAD12EF);
        expectNext("t2_after_B", 2, 32'hDEAD12EF);
        expectNext("t2_dbg_ack_drop", 5, 32'h0);
        stepCycle();

        // Bypass versus read-first on a same-edge write to r4.
        applyStimulus(1'b1, 5'd4, 32'h00000011, 4'hF, 5'd4, 5'd3, 1'b0, 5'd0);
        expectNext("t4_bypass", 0, 32'h00000011);
        expectNext("t4_readfirst_old", 2, 32'h0);
        expectNext("t4_readfirst_other", 3, 32'hDEAD12EF);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd4, 5'd0, 1'b0, 5'd0);
        expectNext("t4_readfirst_new", 2, 32'h00000011);
        expectNext("t4_bypass_hold", 0, 32'h00000011);
        expectNext("t4_r0_zero", 1, 32'h0);
        stepCycle();

        // Register 0 ignores writes; same address on both ports; wbe=0 writes.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 1'b0, 5'd0);
        expectNext("t5_r0_bypass0", 0, 32'h0);
        expectNext("t5_r0_bypass1", 1, 32'h0);
        expectNext("t5_r0_readfirst", 2, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 5'd9, 32'h12345678, 4'hF, 5'd0, 5'd9, 1'b0, 5'd0);
        expectNext("t5_r0_after", 0, 32'h0);
        expectNext("t5_r9_bypass", 1, 32'h12345678);
        expectNext("t5_r9_readfirst", 3, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 5'd10, 32'hAAAAAAAA, 4'h0, 5'd9, 5'd9, 1'b0, 5'd0);
        expectNext("t5_same_addr_A0", 0, 32'h12345678);
        expectNext("t5_same_addr_A1", 1, 32'h12345678);
        expectNext("t5_same_addr_B0", 2, 32'h12345678);
        expectNext("t5_same_addr_B1", 3, 32'h12345678);
        stepCycle();
        applyStimulus(1'b1, 5'd9, 32'h0, 4'h0, 5'd10, 5'd9, 1'b0, 5'd0);
        expectNext("t5_wbe0_no_valid", 0, 32'h0);
        expectNext("t5_wbe0_no_bypass", 1, 32'h12345678);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd10, 1'b0, 5'd0);
        expectNext("t5_wbe0_kept", 0, 32'h12345678);
        expectNext("t5_wbe0_r10", 1, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 5'd7, 32'hFFFFFFFF, 4'hF, 5'd7, 5'd0, 1'b0, 5'd0);
        expectNext("t5_r7_fill", 0, 32'hFFFFFFFF);
        stepCycle();

        // Held debug request: ack every other cycle, capture only from IDLE.
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b1, 5'd9);
        expectNext("t6_held_ack1", 5, 32'h1);
        expectNext("t6_held_data1", 4, 32'h12345678);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b1, 5'd4);
        expectNext("t6_held_gap1", 5, 32'h0);
        expectNext("t6_held_ignored", 4, 32'h12345678);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b1, 5'd3);
        expectNext("t6_held_ack2", 5, 32'h1);
        expectNext("t6_held_data2", 4, 32'hDEAD12EF);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b1, 5'd3);
        expectNext("t6_held_gap2", 5, 32'h0);
        expectNext("t6_held_gapB", 7, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        expectNext("t6_released", 5, 32'h0);
        stepCycle();

        // Reset while in RESP: ack is aborted and debug data clears.
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd9, 1'b1, 5'd9);
        expectNext("t6_pre_reset_ack", 5, 32'h1);
        expectNext("t6_pre_reset_data", 4, 32'h12345678);
        expectNext("t6_pre_reset_r7", 0, 32'hFFFFFFFF);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd9, 1'b0, 5'd0);
        reset = 1'b1;
        #1;
        checkOutput("t6_reset_ackA", {31'b0, ackA}, 32'h0);
        checkOutput("t6_reset_dataA", dataA, 32'h0);
        checkOutput("t6_reset_rdA0", rdA[31:0], 32'h0);
        checkOutput("t6_reset_ackB", {31'b0, ackB}, 32'h0);
        checkOutput("t6_reset_dataB", dataB, 32'h0);
        #1;
        reset = 1'b0;
        expectNext("t6_post_reset_ack", 5, 32'h0);
        expectNext("t6_post_reset_data", 4, 32'h0);
        expectNext("t6_post_reset_r7", 0, 32'h0);
        stepCycle();
        expectNext("t6_post_reset_ack2", 5, 32'h0);
        stepCycle();

        // Partial write into a cleared entry: unwritten bytes read zero.
        applyStimulus(1'b1, 5'd7, 32'h000000AB, 4'h1, 5'd7, 5'd9, 1'b0, 5'd0);
        expectNext("t3_bypass_partial", 0, 32'h000000AB);
        expectNext("t3_r9_cleared", 1, 32'h0);
        expectNext("t3_readfirst_invalid", 2, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd3, 1'b0, 5'd0);
        expectNext("t3_r7_A", 0, 32'h000000AB);
        expectNext("t3_r3_cleared", 1, 32'h0);
        expectNext("t3_r7_B", 2, 32'h000000AB);
        stepCycle();

        checkOutput("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
